irq_ctrl: RTL

//  Memory-mapped interrupt controller feeding the CPU control unit's irqout input.

---
 rtl/mips_irq_pkg.sv | 30 +++
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states,
// trap vector and the CAUSE word layout.
package mips_irq_pkg;

   localparam logic [4:0]  OFF_PEND  = 5'h00;
   localparam logic [4:0]  OFF_MASK  = 5'h04;
   localparam logic [4:0]  OFF_CAUSE = 5'h08;
   localparam logic [4:0]  OFF_STATE = 5'h0C;
   localparam logic [4:0]  OFF_TH    = 5'h10;
   localparam logic [4:0]  OFF_TL    = 5'h14;
   localparam logic [4:0]  OFF_TCON  = 5'h18;

   localparam logic [31:0] TRAP_PC         = 32'h8000_0004;
   localparam int          CAUSE_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   function automatic logic [31:0] cause_word(input logic valid, input logic [2:0] idx);
      logic [31:0] w;
      w                  = 32'h0000_0000;
      w[CAUSE_VALID_BIT] = valid;
      w[2:0]             = idx;
      return w;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_prio_enc #(
   parameter int W = 4
) (
   input  logic [W-1:0] req,
   output logic         any,
   output logic [3:0]   idx
);

   // Scan from the top down so the lowest set bit is the last one to claim idx.
   always_comb begin
      any = |req;
      idx = 4'd0;
      for (int i = W - 1; i >= 0; i--) begin
         idx = req[i] ? 4'(i) : idx;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped edge-triggered interrupt controller driving the CPU irqout line.
// Optional timer source enabled by defining IRQ_CTRL_TIMER_EN.
module irq_ctrl
   import mips_irq_pkg::*;
#(
   parameter int          NUM_SRC   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [31:0]        pc,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               mem_wr,
   input  logic               mem_rd,
   output logic [31:0]        rdata,
   output logic               irqout
);

`ifdef IRQ_CTRL_TIMER_EN
   localparam int NP = NUM_SRC + 1;
`else
   localparam int NP = NUM_SRC;
`endif

   logic [NUM_SRC-1:0] sync1_r;
   logic [NUM_SRC-1:0] sync2_r;
   logic [NUM_SRC-1:0] sync3_r;
   logic [NUM_SRC-1:0] edge_s;
   logic [NUM_SRC-1:0] w1c_s;
   logic [NUM_SRC-1:0] ack_clr_s;
   logic [NP-1:0]      pend_r;
   logic [NP-1:0]      pend_d;
   logic [NP-1:0]      mask_r;
   logic [NP-1:0]      active_s;
   irq_state_e         state_r;
   logic               irqout_r;
   logic               cause_valid_r;
   logic [2:0]         cause_idx_r;
   logic               pc31_r;
   logic               blk_hit_s;
   logic [4:0]         off_s;
   logic               wr_pend_s;
   logic               wr_mask_s;
   logic               any_s;
   logic [3:0]         win_s;
   logic               ack_s;
   logic               unused_s;

`ifdef IRQ_CTRL_TIMER_EN
   logic [31:0] th_r;
   logic [31:0] tl_r;
   logic [2:0]  tcon_r;
   logic        wr_th_s;
   logic        wr_tl_s;
   logic        wr_tcon_s;
   logic        wrap_s;
   logic        tmr_lvl_s;
`endif

   assign blk_hit_s = (addr[31:5] == BASE_ADDR[31:5]);
   assign off_s     = addr[4:0];
   assign wr_pend_s = mem_wr & blk_hit_s & (off_s == OFF_PEND);
   assign wr_mask_s = mem_wr & blk_hit_s & (off_s == OFF_MASK);
   assign edge_s    = sync2_r & ~sync3_r;
   assign active_s  = pend_r & mask_r;
   assign ack_s     = (state_r == REQ) && (pc == TRAP_PC) && any_s;
   assign irqout    = irqout_r;
   assign unused_s  = ^{1'b0, wdata, win_s};

   irq_prio_enc #(
      .W (NP)
   ) u_prio (
      .req (active_s),
      .any (any_s),
      .idx (win_s)
   );

   // Two-flop synchroniser plus a third stage for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= {NUM_SRC{1'b0}};
         sync2_r <= {NUM_SRC{1'b0}};
         sync3_r <= {NUM_SRC{1'b0}};
      end else begin
         sync1_r <= irq_src;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   // Next pending vector: a fresh edge beats both a W1C and the ack clear.
   always_comb begin
      w1c_s  = wr_pend_s ? wdata[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
      pend_d = {NP{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr_s[i] = ack_s && (win_s == 4'(i));
      end
      pend_d[NUM_SRC-1:0] = (pend_r[NUM_SRC-1:0] & ~w1c_s & ~ack_clr_s) | edge_s;
`ifdef IRQ_CTRL_TIMER_EN
      pend_d[NUM_SRC] = tmr_lvl_s;
`endif
   end

   // Pending and mask registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_r <= {NP{1'b0}};
         mask_r <= {NP{1'b0}};
      end else begin
         pend_r <= pend_d;
         if (wr_mask_s) begin
            mask_r <= wdata[NP-1:0];
         end else begin
            mask_r <= mask_r;
         end
      end
   end

   // Request FSM; the winner is taken at the ack cycle so a late higher source wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         irqout_r      <= 1'b0;
         cause_valid_r <= 1'b0;
         cause_idx_r   <= 3'd0;
         pc31_r        <= 1'b0;
      end else begin
         pc31_r <= pc[31];
         case (state_r)
            IDLE: begin
               if (any_s && !pc[31]) begin
                  state_r  <= REQ;
                  irqout_r <= 1'b1;
               end else begin
                  irqout_r <= 1'b0;
               end
            end
            REQ: begin
               if (ack_s) begin
                  cause_valid_r <= 1'b1;
                  cause_idx_r   <= win_s[2:0];
                  irqout_r      <= 1'b0;
                  state_r       <= SERVICE;
               end else if (!any_s) begin
                  irqout_r <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  irqout_r <= 1'b1;
               end
            end
            SERVICE: begin
               irqout_r <= 1'b0;
               if (pc31_r && !pc[31]) begin
                  cause_valid_r <= 1'b0;
                  state_r       <= IDLE;
               end else begin
                  state_r <= SERVICE;
               end
            end
            default: begin
               irqout_r <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

`ifdef IRQ_CTRL_TIMER_EN
   assign wr_th_s   = mem_wr & blk_hit_s & (off_s == OFF_TH);
   assign wr_tl_s   = mem_wr & blk_hit_s & (off_s == OFF_TL);
   assign wr_tcon_s = mem_wr & blk_hit_s & (off_s == OFF_TCON);
   assign wrap_s    = tcon_r[0] & (tl_r == 32'hFFFF_FFFF) & ~wr_tl_s;
   assign tmr_lvl_s = tcon_r[2] & tcon_r[1];

   // Free-running timer with reload; a bus write to TL overrides counting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_r   <= 32'h0000_0000;
         tl_r   <= 32'h0000_0000;
         tcon_r <= 3'b000;
      end else begin
         th_r <= wr_th_s ? wdata : th_r;
         if (wr_tl_s) begin
            tl_r <= wdata;
         end else if (tcon_r[0]) begin
            tl_r <= wrap_s ? th_r : tl_r + 32'd1;
         end else begin
            tl_r <= tl_r;
         end
         tcon_r[1:0] <= wr_tcon_s ? wdata[1:0] : tcon_r[1:0];
         tcon_r[2]   <= wrap_s | (tcon_r[2] & ~(wr_tcon_s & wdata[2]));
      end
   end
`endif

   // Combinational read mux; anything unmapped reads zero.
   always_comb begin
      rdata = 32'h0000_0000;
      if (mem_rd && blk_hit_s) begin
         case (off_s)
            OFF_PEND:  rdata = 32'(pend_r);
            OFF_MASK:  rdata = 32'(mask_r);
            OFF_CAUSE: rdata = cause_word(cause_valid_r, cause_idx_r);
            OFF_STATE: rdata = {30'h0, state_r};
`ifdef IRQ_CTRL_TIMER_EN
            OFF_TH:    rdata = th_r;
            OFF_TL:    rdata = tl_r;
            OFF_TCON:  rdata = {29'h0, tcon_r};
`endif
            default:   rdata = 32'h0000_0000;
         endcase
      end else begin
         rdata = 32'h0000_0000;
      end
   end

endmodule
